regfile_context_mover: RTL and testbench
========================================

// Module: regfile_context_mover
// PURPOSE
// Initiator-side companion to the 4-write/8-read CGRA register file. Drives the file's
// read and write ports to save or restore its whole contents. Save streams every register
// out on a valid/ready master port; restore loads every register from a valid/ready slave
// port. Used for CGRA context switch and debug dump. The fabric must not access the file
// while busy=1; this is a system-level rule.
// PARAMETERS
// LOG2REGS  3   log2 of register count; must be >=3. NREGS=2**LOG2REGS, a multiple of 8.
// SIZE      32  data width of a register word.
// PORTS
// CGRA_Clock                in   1         clock, rising edge
// CGRA_Reset_n              in   1         asynchronous reset, active low
// save_start                in   1         pulse; starts save when idle
// restore_start             in   1         pulse; starts restore when idle
// busy                      out  1         high from start acceptance until the done pulse
// save_done / restore_done  out  1 each    one-cycle completion pulses
// m_data, m_valid, m_last   out  SIZE,1,1  save stream out; m_last marks final word
// m_ready                   in   1         save stream sink ready
// s_data, s_valid           in   SIZE,1    restore stream in
// s_ready                   out  1         restore stream accept
// address_out0..7           out  LOG2REGS  file read addresses
// rf_out0..7                in   SIZE      file read data (registered, 1-cycle latency)
// WE0..3                    out  1 each    file write enables
// address_in0..3            out  LOG2REGS  file write addresses
// in0..3                    out  SIZE      file write data
// BEHAVIOUR
// - Reset (async, CGRA_Reset_n=0): state IDLE; every output 0, including addresses,
//   WE, in, m_*, s_ready, busy and done. Counters and buffers cleared. Reset mid-operation
//   abandons it with no done pulse.
// - States: IDLE, S_ADDR, S_CAPT, S_STREAM, R_COLLECT, R_WRITE.
// - IDLE: save_start=1 -> S_ADDR. Otherwise restore_start=1 -> R_COLLECT.
//   Save wins when both are asserted. busy rises at the accepting edge.
//   Starts are ignored while busy.
// - Save batch b (0..NREGS/8-1):
//   - S_ADDR, one cycle: address_outk = b*8+k. These are registered outputs and hold their
//     value until the next S_ADDR.
//   - S_CAPT, one cycle: the file has sampled the addresses. rf_outk is latched into
//     buffer[k] at the exit edge.
//   - S_STREAM: m_data = buffer[word], m_valid=1. Advance word only on m_valid&&m_ready.
//     m_data is stable while stalled. After word 7, go to the next batch's S_ADDR.
//     After the last batch, go to IDLE.
//   - m_last=1 only on word 7 of the final batch.
//   - Latency: first m_valid in the 3rd cycle after the start edge. Order is ascending
//     register index.
// - Final save handshake edge: m_valid -> 0, busy -> 0, save_done=1 for one cycle.
// - R_COLLECT:
//   - s_ready=1. Each s_valid&&s_ready stores s_data into stage[cnt] and increments cnt
//     (0..3).
//   - The 4th beat moves to R_WRITE, and s_ready falls at that edge.
// - R_WRITE, one cycle:
//   - WE0..3=1, address_ink = base+k, ink = stage[k].
//   - The file commits at the exit edge, then base += 4.
//   - If base wraps to 0 (NREGS written): IDLE, busy -> 0, restore_done=1 for one cycle.
//     Otherwise: R_COLLECT, WE -> 0.
// - WE0..3 are 0 in every other state. Write addresses within a cycle are always distinct.
// - All counters are mod NREGS or mod 8/4. No state persists across operations except the
//   address_out hold.
// TESTING
// - Assert reset mid-S_STREAM: all outputs 0 immediately, busy=0. After release, save_start
//   must run a full clean save.
// - File preloaded reg[i]=0xA0+i, m_ready=1, save_start: m_valid in the 3rd cycle,
//   m_data 0xA0..0xA7 on consecutive cycles, m_last with 0xA7, save_done next cycle.
// - Same save with m_ready toggling 1,0,1,0: no duplicated or dropped words, m_data held
//   while stalled, exactly 8 handshakes.
// - Restore 0x1000+i with s_valid=1:
//   - WE0..3 cycle with addresses 0..3 and data 0x1000..0x1003.
//   - s_ready low for that cycle, then addresses 4..7.
//   - restore_done; a following save returns 0x1000..0x1007.
// - save_start and restore_start in the same cycle -> save runs. Either start pulsed while
//   busy has no effect.
// - LOG2REGS=4: save yields 16 words in two batches (second batch address_outk=8+k).
//   Restore issues 4 write cycles.

Source files
------------

// File: rtl/regfile_context_mover.sv
// regfile_context_mover: saves/restores a whole CGRA register file over valid/ready streams
// Ports: CGRA_Clock/CGRA_Reset_n clock and async active-low reset; save_start/restore_start
// start pulses; busy/save_done/restore_done status; m_data/m_valid/m_last/m_ready save
// stream master; s_data/s_valid/s_ready restore stream slave; address_out0..7 + rf_out0..7
// file read ports (1-cycle read latency); WE0..3/address_in0..3/in0..3 file write ports.
module regfile_context_mover #(
  parameter int LOG2REGS = 3,
  parameter int SIZE = 32
) (
  input  logic                CGRA_Clock,
  input  logic                CGRA_Reset_n,
  input  logic                save_start,
  input  logic                restore_start,
  output logic                busy,
  output logic                save_done,
  output logic                restore_done,
  output logic [SIZE-1:0]     m_data,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  input  logic [SIZE-1:0]     s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [LOG2REGS-1:0] address_out0,
  output logic [LOG2REGS-1:0] address_out1,
  output logic [LOG2REGS-1:0] address_out2,
  output logic [LOG2REGS-1:0] address_out3,
  output logic [LOG2REGS-1:0] address_out4,
  output logic [LOG2REGS-1:0] address_out5,
  output logic [LOG2REGS-1:0] address_out6,
  output logic [LOG2REGS-1:0] address_out7,
  input  logic [SIZE-1:0]     rf_out0,
  input  logic [SIZE-1:0]     rf_out1,
  input  logic [SIZE-1:0]     rf_out2,
  input  logic [SIZE-1:0]     rf_out3,
  input  logic [SIZE-1:0]     rf_out4,
  input  logic [SIZE-1:0]     rf_out5,
  input  logic [SIZE-1:0]     rf_out6,
  input  logic [SIZE-1:0]     rf_out7,
  output logic                WE0,
  output logic                WE1,
  output logic                WE2,
  output logic                WE3,
  output logic [LOG2REGS-1:0] address_in0,
  output logic [LOG2REGS-1:0] address_in1,
  output logic [LOG2REGS-1:0] address_in2,
  output logic [LOG2REGS-1:0] address_in3,
  output logic [SIZE-1:0]     in0,
  output logic [SIZE-1:0]     in1,
  output logic [SIZE-1:0]     in2,
  output logic [SIZE-1:0]     in3
);
  localparam int NREGS = 2 ** LOG2REGS;
  typedef enum logic [2:0] {IDLE, S_ADDR, S_CAPT, S_STREAM, R_COLLECT, R_WRITE} state_t;
  state_t              state_q;
  logic [LOG2REGS-1:0] raddr_q [8];
  logic [LOG2REGS-1:0] waddr_q [4];
  logic [SIZE-1:0]     wdata_q [4];
  logic [SIZE-1:0]     stage_q [4];
  logic [SIZE-1:0]     buf_q [8];
  logic [SIZE-1:0]     rf_out [8];
  logic [LOG2REGS-1:0] sbase_q, rbase_q;
  logic [2:0]          word_q;
  logic [1:0]          cnt_q;
  logic                we_q, m_valid_q, m_last_q, s_ready_q, busy_q, save_done_q, restore_done_q;
  logic [SIZE-1:0]     m_data_q;
  logic                last_batch;
  assign rf_out = '{rf_out0, rf_out1, rf_out2, rf_out3, rf_out4, rf_out5, rf_out6, rf_out7};
  assign last_batch = sbase_q == LOG2REGS'(NREGS - 8);
  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
    if (!CGRA_Reset_n) begin
      state_q <= IDLE;
      for (int k = 0; k < 8; k++) begin
        raddr_q[k] <= '0;
        buf_q[k] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        waddr_q[k] <= '0;
        wdata_q[k] <= '0;
        stage_q[k] <= '0;
      end
      sbase_q <= '0;
      rbase_q <= '0;
      word_q <= '0;
      cnt_q <= '0;
      we_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q <= 1'b0;
      m_data_q <= '0;
      s_ready_q <= 1'b0;
      busy_q <= 1'b0;
      save_done_q <= 1'b0;
      restore_done_q <= 1'b0;
    end else begin
      save_done_q <= 1'b0;
      restore_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (save_start) begin
            state_q <= S_ADDR;
            busy_q <= 1'b1;
            sbase_q <= '0;
            for (int k = 0; k < 8; k++) raddr_q[k] <= LOG2REGS'(k);
          end else if (restore_start) begin
            state_q <= R_COLLECT;
            busy_q <= 1'b1;
            s_ready_q <= 1'b1;
            cnt_q <= '0;
            rbase_q <= '0;
          end
        end
        S_ADDR: state_q <= S_CAPT;
        S_CAPT: begin
          state_q <= S_STREAM;
          buf_q <= rf_out;
          m_data_q <= rf_out[0];
          m_valid_q <= 1'b1;
          word_q <= '0;
        end
        S_STREAM: begin
          if (m_valid_q && m_ready) begin
            word_q <= word_q + 3'd1;
            m_data_q <= buf_q[word_q + 3'd1];
            m_last_q <= last_batch && word_q == 3'd6;
            if (word_q == 3'd7) begin
              m_valid_q <= 1'b0;
              m_last_q <= 1'b0;
              if (last_batch) begin
                state_q <= IDLE;
                busy_q <= 1'b0;
                save_done_q <= 1'b1;
                sbase_q <= '0;
              end else begin
                state_q <= S_ADDR;
                sbase_q <= sbase_q + LOG2REGS'(8);
                for (int k = 0; k < 8; k++) raddr_q[k] <= sbase_q + LOG2REGS'(8) + LOG2REGS'(k);
              end
            end
          end
        end
        R_COLLECT: begin
          if (s_valid && s_ready_q) begin
            stage_q[cnt_q] <= s_data;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= R_WRITE;
              s_ready_q <= 1'b0;
              we_q <= 1'b1;
              for (int k = 0; k < 4; k++) begin
                waddr_q[k] <= rbase_q + LOG2REGS'(k);
                wdata_q[k] <= k == 3 ? s_data : stage_q[k];
              end
            end
          end
        end
        R_WRITE: begin
          we_q <= 1'b0;
          rbase_q <= rbase_q + LOG2REGS'(4);
          if (rbase_q == LOG2REGS'(NREGS - 4)) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            restore_done_q <= 1'b1;
          end else begin
            state_q <= R_COLLECT;
            s_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign save_done = save_done_q;
  assign restore_done = restore_done_q;
  assign m_data = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last = m_last_q;
  assign s_ready = s_ready_q;
  assign address_out0 = raddr_q[0];
  assign address_out1 = raddr_q[1];
  assign address_out2 = raddr_q[2];
  assign address_out3 = raddr_q[3];
  assign address_out4 = raddr_q[4];
  assign address_out5 = raddr_q[5];
  assign address_out6 = raddr_q[6];
  assign address_out7 = raddr_q[7];
  assign WE0 = we_q;
  assign WE1 = we_q;
  assign WE2 = we_q;
  assign WE3 = we_q;
  assign address_in0 = waddr_q[0];
  assign address_in1 = waddr_q[1];
  assign address_in2 = waddr_q[2];
  assign address_in3 = waddr_q[3];
  assign in0 = wdata_q[0];
  assign in1 = wdata_q[1];
  assign in2 = wdata_q[2];
  assign in3 = wdata_q[3];
endmodule

// File: tb/tb_regfile_context_mover.sv
// tb_regfile_context_mover: scoreboard bench with a register file model and a reference memory
module tb_regfile_context_mover;
  localparam int L = 4;
  localparam int W = 32;
  localparam int N = 1 << L;
  typedef struct packed {logic [W-1:0] d; logic last;} beat_t;
  logic clk = 1'b0;
  logic rst_n;
  logic save_start = 1'b0, restore_start = 1'b0, m_ready = 1'b1, s_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic busy, save_done, restore_done, m_valid, m_last, s_ready, we0, we1, we2, we3;
  logic [W-1:0] m_data;
  logic [L-1:0] ao [8];
  logic [L-1:0] ai [4];
  logic [W-1:0] wd [4];
  logic [W-1:0] rf [8];
  logic [W-1:0] regs [N];
  logic [W-1:0] mem [N];
  logic pre = 1'b0;
  beat_t exp_q [$];
  int wq_base [$];
  logic [W-1:0] wq_dat [$];
  int n_chk = 0, n_fail = 0;
  int rmode = 0;
  logic tog = 1'b0;
  logic held = 1'b0;
  logic [W-1:0] hold_d = '0;
  logic outs_or;
  always #5 clk = ~clk;
  regfile_context_mover #(.LOG2REGS(L), .SIZE(W)) dut (
    .CGRA_Clock(clk), .CGRA_Reset_n(rst_n),
    .save_start(save_start), .restore_start(restore_start),
    .busy(busy), .save_done(save_done), .restore_done(restore_done),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .address_out0(ao[0]), .address_out1(ao[1]), .address_out2(ao[2]), .address_out3(ao[3]),
    .address_out4(ao[4]), .address_out5(ao[5]), .address_out6(ao[6]), .address_out7(ao[7]),
    .rf_out0(rf[0]), .rf_out1(rf[1]), .rf_out2(rf[2]), .rf_out3(rf[3]),
    .rf_out4(rf[4]), .rf_out5(rf[5]), .rf_out6(rf[6]), .rf_out7(rf[7]),
    .WE0(we0), .WE1(we1), .WE2(we2), .WE3(we3),
    .address_in0(ai[0]), .address_in1(ai[1]), .address_in2(ai[2]), .address_in3(ai[3]),
    .in0(wd[0]), .in1(wd[1]), .in2(wd[2]), .in3(wd[3])
  );
  assign outs_or = |{busy, save_done, restore_done, m_valid, m_last, s_ready, we0, we1, we2, we3,
                     m_data, ao[0], ao[1], ao[2], ao[3], ao[4], ao[5], ao[6], ao[7],
                     ai[0], ai[1], ai[2], ai[3], wd[0], wd[1], wd[2], wd[3]};
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Register file: registered 1-cycle reads, 4 write ports committed at the clock edge.
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) rf[k] <= regs[ao[k]];
    if (pre) begin
      for (int i = 0; i < N; i++) regs[i] <= 32'hA0 + i;
    end else begin
      if (we0) regs[ai[0]] <= wd[0];
      if (we1) regs[ai[1]] <= wd[1];
      if (we2) regs[ai[2]] <= wd[2];
      if (we3) regs[ai[3]] <= wd[3];
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    tog = ~tog;
    m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? tog : rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  always @(negedge clk) begin : monitor
    beat_t e;
    int b;
    if (!rst_n) held = 1'b0;
    else begin
      if (m_valid) begin
        if (held) check("m_data_hold", m_data, hold_d);
        if (m_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL m_extra: got %0h expected no word", m_data);
          end else begin
            e = exp_q.pop_front();
            check("m_data", m_data, e.d);
            check("m_last", m_last, e.last);
          end
        end else begin
          held = 1'b1;
          hold_d = m_data;
        end
      end
      if (we0 | we1 | we2 | we3) begin
        check("we_all", {we0, we1, we2, we3}, 4'hF);
        check("s_ready_in_write", s_ready, 0);
        if (wq_base.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL wr_extra: got write at %0h expected none", ai[0]);
        end else begin
          b = wq_base.pop_front();
          for (int k = 0; k < 4; k++) begin
            check("wr_addr", ai[k], b + k);
            check("wr_data", wd[k], wq_dat.pop_front());
          end
        end
      end
    end
  end
  task automatic do_save(int mode, bit both, bit poke);
    int c;
    bit got;
    rmode = mode;
    for (int i = 0; i < N; i++) exp_q.push_back(beat_t'{mem[i], (i == N - 1)});
    @(posedge clk); #1;
    save_start = 1'b1;
    restore_start = both;
    @(posedge clk); #1;
    save_start = 1'b0;
    restore_start = 1'b0;
    check("busy_rise", busy, 1);
    check("s_ready_during_save", s_ready, 0);
    check("m_valid_c1", m_valid, 0);
    check("addr_out0", ao[0], 0);
    check("addr_out7", ao[7], 7);
    @(posedge clk); #1;
    check("m_valid_c2", m_valid, 0);
    @(posedge clk); #1;
    check("m_valid_c3", m_valid, 1);
    c = 3;
    got = 1'b0;
    while (!got && c < 4000) begin
      save_start = poke && c == 5;
      restore_start = poke && c == 5;
      @(posedge clk); #1;
      c++;
      if (save_done) got = 1'b1;
    end
    save_start = 1'b0;
    restore_start = 1'b0;
    check("save_done_seen", got, 1);
    if (got) begin
      if (mode == 0) check("save_done_cycle", c, (N / 8) * 10 + 1);
      check("busy_fall", busy, 0);
      check("m_valid_fall", m_valid, 0);
      check("save_words_left", exp_q.size(), 0);
      @(posedge clk); #1;
      check("save_done_pulse", save_done, 0);
      check("idle_after_save", busy, 0);
    end
    exp_q.delete();
  endtask
  task automatic do_restore(bit directed, bit gaps);
    logic [W-1:0] v [N];
    int idx, c;
    bit hs, got;
    for (int i = 0; i < N; i++) begin
      v[i] = directed ? 32'h1000 + i : $urandom;
      mem[i] = v[i];
    end
    for (int j = 0; j < N / 4; j++) begin
      wq_base.push_back(4 * j);
      for (int k = 0; k < 4; k++) wq_dat.push_back(v[4 * j + k]);
    end
    @(posedge clk); #1;
    restore_start = 1'b1;
    @(posedge clk); #1;
    restore_start = 1'b0;
    check("busy_rise_r", busy, 1);
    check("s_ready_c1", s_ready, 1);
    idx = 0;
    c = 0;
    while (idx < N && c < 4000) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = s_valid ? v[idx] : $urandom;
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      c++;
      if (hs) idx++;
    end
    s_valid = 1'b0;
    check("restore_beats", idx, N);
    got = 1'b0;
    c = 0;
    while (!got && c < 50) begin
      if (restore_done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    check("restore_done_seen", got, 1);
    if (got) begin
      check("busy_fall_r", busy, 0);
      check("s_ready_fall", s_ready, 0);
      check("writes_left", wq_base.size(), 0);
      @(posedge clk); #1;
      check("restore_done_pulse", restore_done, 0);
    end
    wq_base.delete();
    wq_dat.delete();
  endtask
  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_outs_async", outs_or, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_held", outs_or, 0);
    rst_n = 1'b1;
    pre = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = 32'hA0 + i;
    @(posedge clk); #1;
    pre = 1'b0;
    do_save(0, 0, 0);
    do_save(1, 0, 0);
    do_restore(1, 0);
    do_save(0, 0, 0);
    do_save(2, 1, 1);
    for (int r = 0; r < 3; r++) begin
      do_restore(0, 1);
      do_save(2, 0, 0);
    end
    rmode = 3;
    @(posedge clk); #1;
    save_start = 1'b1;
    @(posedge clk); #1;
    save_start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("pre_reset_streaming", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_outs", outs_or, 0);
    check("reset_mid_busy", busy, 0);
    exp_q.delete();
    @(posedge clk); #1;
    check("reset_mid_held", outs_or, 0);
    rst_n = 1'b1;
    do_save(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
